ro_period_monitor: RTL and testbench

RO_PERIOD_MONITOR -- requirements
Module: ro_period_monitor

---
 rtl/ro_period_monitor.sv | 149 ++++++++++++++
 tb/tb_ro_period_monitor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_period_monitor.sv
// Measures the period, in valid samples, of a 5-bit upstream sequence generator.
// Optional idle watchdog is compiled in when WATCHDOG_EN is defined.
//
// state   | meaning
// IDLE    | waiting for Start after reset
// CAPTURE | waiting for the first valid sample to use as reference
// MEASURE | counting valid samples until the reference recurs
// DONE    | Period valid, held until next Start
// FAULT   | measurement aborted, FaultCode held until next Start
module ro_period_monitor #(
    parameter int MAX_PERIOD = 63,
    parameter int WD_LIMIT   = 16
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Valid,
    input  logic [4:0] RO_in,
    output logic       Busy,
    output logic       Done,
    output logic [5:0] Period,
    output logic       Fault,
    output logic [1:0] FaultCode
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_MEASURE,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [1:0] FC_ZERO     = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [5:0] MAX_CNT     = 6'(MAX_PERIOD);

    if (MAX_PERIOD < 2 || MAX_PERIOD > 63) begin : g_bad_max
        $error("MAX_PERIOD out of range 2..63");
    end
    if (WD_LIMIT < 2 || WD_LIMIT > 255) begin : g_bad_wd
        $error("WD_LIMIT out of range 2..255");
    end

    state_t     state_q;
    logic [4:0] ref_q;
    logic [5:0] cnt_q;
    logic [5:0] cnt_d;
    logic       busy_q;
    logic       done_q;
    logic       fault_q;
    logic [1:0] fcode_q;
    logic [5:0] period_q;

    assign cnt_d = cnt_q + 6'd1;

`ifdef WATCHDOG_EN
    localparam logic [1:0] FC_WATCHDOG = 2'b11;
    localparam logic [7:0] WD_MAX      = 8'(WD_LIMIT);
    logic [7:0] wd_q;
    logic [7:0] wd_d;
    assign wd_d = wd_q + 8'd1;
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            ref_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            fcode_q  <= '0;
            period_q <= '0;
`ifdef WATCHDOG_EN
            wd_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAULT: begin
                    if (Start) begin
                        state_q  <= S_CAPTURE;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        fault_q  <= 1'b0;
                        fcode_q  <= '0;
                        period_q <= '0;
                        cnt_q    <= '0;
`ifdef WATCHDOG_EN
                        wd_q     <= '0;
`endif
                    end
                end
                S_CAPTURE, S_MEASURE: begin
                    if (Valid) begin
`ifdef WATCHDOG_EN
                        wd_q <= '0;
`endif
                        // zero lockup beats match, match beats timeout
                        if (RO_in == 5'd0) begin
                            state_q <= S_FAULT;
                            busy_q  <= 1'b0;
                            fault_q <= 1'b1;
                            fcode_q <= FC_ZERO;
                        end else if (state_q == S_CAPTURE) begin
                            ref_q   <= RO_in;
                            cnt_q   <= '0;
                            state_q <= S_MEASURE;
                        end else if (RO_in == ref_q) begin
                            period_q <= cnt_d;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_DONE;
                        end else if (cnt_d == MAX_CNT) begin
                            state_q <= S_FAULT;
                            busy_q  <= 1'b0;
                            fault_q <= 1'b1;
                            fcode_q <= FC_TIMEOUT;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
`ifdef WATCHDOG_EN
                    else if (wd_d == WD_MAX) begin
                        state_q <= S_FAULT;
                        busy_q  <= 1'b0;
                        fault_q <= 1'b1;
                        fcode_q <= FC_WATCHDOG;
                        wd_q    <= '0;
                    end else begin
                        wd_q <= wd_d;
                    end
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Period    = period_q;
    assign Fault     = fault_q;
    assign FaultCode = fcode_q;

endmodule

// File: tb/tb_ro_period_monitor.sv
// Bench for ro_period_monitor: directed sequences plus randomized sample streams
// checked against a sample-list reference model.
module tb_ro_period_monitor;

    localparam int MAX_PERIOD = 63;
    localparam int WD_LIMIT   = 16;

    typedef struct packed {
        logic       start;
        logic       valid;
        logic [4:0] ro;
    } samp_t;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Valid = 1'b0;
    logic [4:0] RO_in = '0;
    logic       Busy;
    logic       Done;
    logic [5:0] Period;
    logic       Fault;
    logic [1:0] FaultCode;

    int n_cmp = 0;
    int n_err = 0;

    ro_period_monitor #(
        .MAX_PERIOD(MAX_PERIOD),
        .WD_LIMIT  (WD_LIMIT)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .Valid    (Valid),
        .RO_in    (RO_in),
        .Busy     (Busy),
        .Done     (Done),
        .Period   (Period),
        .Fault    (Fault),
        .FaultCode(FaultCode)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic samp_t mk(input logic st, input logic v, input logic [4:0] r);
        samp_t s;
        s.start = st;
        s.valid = v;
        s.ro    = r;
        return s;
    endfunction

    // Walk the sample list as the spec describes the measurement:
    // first valid sample is the reference, period = valid samples until it recurs.
    function automatic void model(input samp_t s[$], output int idx,
                                  output logic [5:0] per, output logic [1:0] code);
        logic [4:0] r;
        bit         have_ref;
        int         n;
        int         idle;
        have_ref = 0;
        r = '0;
        n = 0;
        idle = 0;
        idx = -1;
        per = '0;
        code = 2'b00;
        for (int i = 0; i < s.size(); i++) begin
            if (s[i].valid) begin
                idle = 0;
                if (s[i].ro == 5'd0) begin
                    code = 2'b01; idx = i; return;
                end
                if (!have_ref) begin
                    r = s[i].ro; have_ref = 1; n = 0;
                end else begin
                    n++;
                    if (s[i].ro == r) begin
                        per = 6'(n); idx = i; return;
                    end
                    if (n == MAX_PERIOD) begin
                        code = 2'b10; idx = i; return;
                    end
                end
            end else begin
                idle++;
`ifdef WATCHDOG_EN
                if (idle == WD_LIMIT) begin
                    code = 2'b11; idx = i; return;
                end
`endif
            end
        end
    endfunction

    task automatic pulse_reset();
        #2 Reset = 1'b0;
        #1 Reset = 1'b1;
        @(negedge CLK);
    endtask

    // Start a measurement, stream the samples, and check outputs against the model.
    task automatic run_meas(input string tag, input samp_t s[$], output int idx_o,
                            output logic [5:0] per_o, output logic [1:0] code_o);
        int         idx;
        logic [5:0] per;
        logic [1:0] code;
        logic       exp_done;
        model(s, idx, per, code);
        idx_o = idx; per_o = per; code_o = code;
        exp_done = (idx >= 0) && (code == 2'b00);
        Start = 1'b1; Valid = 1'b0; RO_in = '0;
        tick();
        Start = 1'b0;
        chk({tag, "_start"}, {Busy, Done, Fault, FaultCode, Period}, {1'b1, 1'b0, 1'b0, 2'b00, 6'd0});
        for (int i = 0; i < s.size(); i++) begin
            Start = s[i].start; Valid = s[i].valid; RO_in = s[i].ro;
            tick();
            if (i == idx) break;
            if (i == idx - 1) chk({tag, "_pre"}, {Busy, Done, Fault}, 3'b100);
        end
        Start = 1'b0; Valid = 1'b0;
        if (idx >= 0) begin
            chk({tag, "_res"}, {Busy, Done, Fault, FaultCode, Period},
                {1'b0, exp_done, ~exp_done, code, per});
            for (int k = 0; k < 3; k++) begin
                Valid = 1'($urandom_range(0, 1)); RO_in = 5'($urandom_range(0, 31));
                tick();
            end
            Valid = 1'b0;
            chk({tag, "_hold"}, {Busy, Done, Fault, FaultCode, Period},
                {1'b0, exp_done, ~exp_done, code, per});
        end else begin
            chk({tag, "_busy"}, {Busy, Done, Fault}, 3'b100);
            pulse_reset();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        samp_t      q[$];
        int         idx;
        logic [5:0] per;
        logic [1:0] code;
        logic [4:0] lf;
        logic [4:0] rnd_ref;
        int         len;
        int         x;

        @(negedge CLK);
        @(negedge CLK);
        chk("reset_outs", {Busy, Done, Fault, FaultCode, Period}, 11'd0);
        Reset = 1'b1;
        @(negedge CLK);
        chk("idle_outs", {Busy, Done, Fault, FaultCode, Period}, 11'd0);

        // ring counter, period 5
        q = {};
        q.push_back(mk(0, 1, 5'b00010)); q.push_back(mk(0, 1, 5'b00100));
        q.push_back(mk(0, 1, 5'b01000)); q.push_back(mk(0, 1, 5'b10000));
        q.push_back(mk(0, 1, 5'b00001)); q.push_back(mk(0, 1, 5'b00010));
        run_meas("ring", q, idx, per, code);
        chk("ring_period", Period, 6'd5);

        // max-length LFSR x^5+x^3+1
        q = {};
        lf = 5'b00010;
        q.push_back(mk(0, 1, lf));
        for (int i = 0; i < 31; i++) begin
            lf = {lf[3:0], lf[4] ^ lf[2]};
            q.push_back(mk(0, 1, lf));
        end
        run_meas("lfsr", q, idx, per, code);
        chk("lfsr_period", Period, 6'd31);
        chk("lfsr_idx", 32'(idx), 32'd31);

        // zero lockup at capture
        q = {};
        q.push_back(mk(0, 1, 5'b00000));
        run_meas("zero_cap", q, idx, per, code);
        chk("zero_cap_code", {Fault, FaultCode, Done, Busy}, {1'b1, 2'b01, 1'b0, 1'b0});

        // timeout on the 63rd sample after the reference
        q = {};
        q.push_back(mk(0, 1, 5'b00011));
        for (int i = 0; i < 70; i++) q.push_back(mk(0, 1, (i % 2 == 0) ? 5'b00101 : 5'b00110));
        run_meas("timeout", q, idx, per, code);
        chk("timeout_code", {Fault, FaultCode}, {1'b1, 2'b10});
        chk("timeout_idx", 32'(idx), 32'd63);

        // long idle gap after the reference
        q = {};
        q.push_back(mk(0, 1, 5'b00011));
        for (int i = 0; i < 100; i++) q.push_back(mk(0, 0, 5'b00011));
`ifdef WATCHDOG_EN
        run_meas("wdog", q, idx, per, code);
        chk("wdog_code", {Fault, FaultCode}, {1'b1, 2'b11});
`else
        run_meas("no_wdog", q, idx, per, code);
        chk("no_wdog_busy_after_reset", Busy, 1'b0);
`endif

        // async reset mid-measure
        Start = 1'b1; tick(); Start = 1'b0;
        Valid = 1'b1; RO_in = 5'b00010; tick();
        RO_in = 5'b00100; tick();
        Valid = 1'b0;
        #2 Reset = 1'b0;
        #1 chk("async_reset", {Busy, Done, Fault, FaultCode, Period}, 11'd0);
        Reset = 1'b1;
        @(negedge CLK);
        q = {};
        q.push_back(mk(0, 1, 5'b00010)); q.push_back(mk(0, 1, 5'b00100));
        q.push_back(mk(0, 1, 5'b01000)); q.push_back(mk(0, 1, 5'b10000));
        q.push_back(mk(0, 1, 5'b00001)); q.push_back(mk(0, 1, 5'b00010));
        run_meas("ring_after_reset", q, idx, per, code);
        chk("ring_after_reset_period", Period, 6'd5);

        // randomized streams with gaps, stray Starts, zeros and recurring reference
        for (int t = 0; t < 40; t++) begin
            q = {};
            rnd_ref = 5'($urandom_range(1, 31));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                q.push_back(mk(1'($urandom_range(0, 1)), 0, 5'($urandom_range(0, 31))));
            q.push_back(mk(0, 1, rnd_ref));
            len = $urandom_range(5, 80);
            for (int k = 0; k < len; k++) begin
                x = $urandom_range(0, 99);
                q.push_back(mk(($urandom_range(0, 9) == 0),
                               ($urandom_range(0, 9) < 8),
                               (x < 2) ? 5'd0 : (x < 7) ? rnd_ref : 5'($urandom_range(1, 31))));
            end
            run_meas($sformatf("rnd%0d", t), q, idx, per, code);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
